parking_coin_loader: RTL and testbench
======================================

PARKING_COIN_LOADER -- requirements
Module: parking_coin_loader

Interface
REQ-001 Parameters SHALL be, one per line (name, default, meaning):
- VAL0, 50, seconds added by coin[0]
- VAL1, 150, seconds added by coin[1]
- VAL2, 200, seconds added by coin[2]
- VAL3, 500, seconds added by coin[3]
- PRESET_A, 15, value loaded by preset_a
- PRESET_B, 185, value loaded by preset_b
- TIME_MAX, 9999, saturation ceiling
REQ-002 Ports SHALL be, one per line (name, direction, width, meaning):
- clk, input, 1, single system clock; all logic on rising edge
- rst_n, input, 1, synchronous, active-low reset
- coin, input, 4, asynchronous coin-button levels, one bit per denomination
- preset_a, input, 1, asynchronous button: load PRESET_A
- preset_b, input, 1, asynchronous button: load PRESET_B
- time_cur, input, 14, current remaining time from the downstream decrementer
- time_load, output, 14, new time value presented to the decrementer Timein
- load_en, output, 1, one-cycle strobe: decrementer captures time_load
- busy, output, 1, high whenever state is not IDLE
REQ-003 The block SHALL use one clock and a synchronous, active-low reset; no other clock or asynchronous reset is permitted.

Function
REQ-004 Each of the 6 button inputs SHALL pass through a 2-flop synchronizer before any use.
REQ-005 The FSM SHALL have exactly 4 states: IDLE, ADD, LOAD, RELEASE.
REQ-006 IDLE: if any synchronized request is high, latch the single highest-priority request and go to ADD; otherwise stay.
REQ-007 Priority SHALL be preset_b > preset_a > coin[3] > coin[2] > coin[1] > coin[0]; lower-priority simultaneous requests are discarded, not queued.
REQ-008 ADD: time_load SHALL be registered as the preset value (for a preset) or min(time_cur + VALn, TIME_MAX) (for a coin); go to LOAD.
REQ-009 The addition SHALL use a 15-bit intermediate, so no wrap-around occurs for any 14-bit time_cur.
REQ-010 A time_cur value above TIME_MAX on a coin event SHALL produce TIME_MAX.
REQ-011 LOAD: load_en SHALL be 1 for exactly this one cycle, with time_load stable; go to RELEASE.
REQ-012 RELEASE: remain until all 6 synchronized inputs are low, then go to IDLE; one press yields exactly one load_en regardless of hold time.
REQ-013 Latency: a synchronized request first high in IDLE at cycle N SHALL give load_en high at cycle N+2.
REQ-014 time_load SHALL hold its last value outside ADD.
REQ-015 load_en SHALL be 0 in every state other than LOAD.

Reset
REQ-016 While rst_n is low at a rising clk edge, the block SHALL clear the state to IDLE, time_load to 0, load_en to 0, busy to 0, and all synchronizer flops to 0.
REQ-017 Reset asserted in ADD or LOAD SHALL abort the operation with no load_en pulse on the following cycle.
REQ-018 A button still held when reset deasserts SHALL be treated as a new press.

Structure
REQ-019 A shared package SHALL hold the state enumeration, the default denomination and preset constants, TIME_MAX, and the 14-bit time-width constant, shared with the decrementer.
REQ-020 The 2-flop synchronizer SHALL be a sub-module named sync_2ff, instantiated 6 times (or once with a 6-bit width).

Verification
REQ-021 Bench SHALL cover these scenarios:
- time_cur=500, pulse coin[3] for 10 cycles -> one load_en, time_load=1000, load_en exactly 4 cycles after the raw edge.
- time_cur=9800, coin[2] -> time_load=9999 (saturated); time_cur=16383, coin[0] -> 9999.
- coin[1] and preset_a raised in the same cycle, time_cur=40 -> single load_en, time_load=15; coin[1] ignored.
- time_cur=0, coin[0] held for 200 cycles -> exactly one load_en, time_load=50; release and re-press -> second load_en.
- rst_n low for one cycle while in ADD -> no load_en, time_load=0, busy=0, then IDLE.
- preset_b with time_cur=7000 -> time_load=185, with busy high from ADD through RELEASE.

Source files
------------

// File: rtl/parking_coin_loader_pkg.sv
// Shared constants, state and request encodings for the parking-meter coin loader
// and the downstream time decrementer.
package parking_coin_loader_pkg;

  localparam int unsigned TIME_W  = 14;
  localparam int unsigned SUM_W   = TIME_W + 1;
  localparam int unsigned NUM_BTN = 6;

  localparam int unsigned DEF_VAL0     = 50;
  localparam int unsigned DEF_VAL1     = 150;
  localparam int unsigned DEF_VAL2     = 200;
  localparam int unsigned DEF_VAL3     = 500;
  localparam int unsigned DEF_PRESET_A = 15;
  localparam int unsigned DEF_PRESET_B = 185;
  localparam int unsigned DEF_TIME_MAX = 9999;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_ADD     = 2'd1,
    ST_LOAD    = 2'd2,
    ST_RELEASE = 2'd3
  } state_e;

  typedef enum logic [2:0] {
    REQ_C0 = 3'd0,
    REQ_C1 = 3'd1,
    REQ_C2 = 3'd2,
    REQ_C3 = 3'd3,
    REQ_PA = 3'd4,
    REQ_PB = 3'd5
  } req_e;

  // Button vector is {preset_b, preset_a, coin[3:0]}; higher bit wins.
  function automatic req_e pick_req(input logic [NUM_BTN-1:0] btn);
    req_e r;
    if      (btn[5]) r = REQ_PB;
    else if (btn[4]) r = REQ_PA;
    else if (btn[3]) r = REQ_C3;
    else if (btn[2]) r = REQ_C2;
    else if (btn[1]) r = REQ_C1;
    else             r = REQ_C0;
    return r;
  endfunction

endpackage

// File: rtl/parking_coin_loader_sync_2ff.sv
// Two-flop synchronizer for asynchronous button levels, synchronous active-low clear.
module sync_2ff #(
  parameter int unsigned W = 1
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [W-1:0] d_i,
  output logic [W-1:0] q_o
);

  logic [W-1:0] meta_q;
  logic [W-1:0] sync_q;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      meta_q <= '0;
      sync_q <= '0;
    end else begin
      meta_q <= d_i;
      sync_q <= meta_q;
    end
  end

  assign q_o = sync_q;

endmodule

// File: rtl/parking_coin_loader.sv
// Coin / preset front end: turns one button press into one saturated load of the
// decrementer's time register.
module parking_coin_loader
  import parking_coin_loader_pkg::*;
#(
  parameter int unsigned VAL0     = DEF_VAL0,
  parameter int unsigned VAL1     = DEF_VAL1,
  parameter int unsigned VAL2     = DEF_VAL2,
  parameter int unsigned VAL3     = DEF_VAL3,
  parameter int unsigned PRESET_A = DEF_PRESET_A,
  parameter int unsigned PRESET_B = DEF_PRESET_B,
  parameter int unsigned TIME_MAX = DEF_TIME_MAX
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [3:0]        coin,
  input  logic              preset_a,
  input  logic              preset_b,
  input  logic [TIME_W-1:0] time_cur,
  output logic [TIME_W-1:0] time_load,
  output logic              load_en,
  output logic              busy
);

  logic [NUM_BTN-1:0] btn_raw;
  logic [NUM_BTN-1:0] btn_sync;

  state_e state_q, state_d;
  req_e   req_q,   req_d;

  logic [TIME_W-1:0] time_load_q, time_load_d;
  logic              load_en_q,   load_en_d;
  logic              busy_q,      busy_d;

  logic [SUM_W-1:0]  coin_val;
  logic [SUM_W-1:0]  coin_sum;
  logic [TIME_W-1:0] coin_sat;

  assign btn_raw = {preset_b, preset_a, coin};

  sync_2ff #(.W(NUM_BTN)) u_sync (
    .clk   (clk),
    .rst_n (rst_n),
    .d_i   (btn_raw),
    .q_o   (btn_sync)
  );

  // Coin denomination and saturating add; 15-bit sum cannot wrap for any 14-bit input.
  always_comb begin
    coin_val = SUM_W'(VAL0);
    case (req_q)
      REQ_C1:  coin_val = SUM_W'(VAL1);
      REQ_C2:  coin_val = SUM_W'(VAL2);
      REQ_C3:  coin_val = SUM_W'(VAL3);
      default: coin_val = SUM_W'(VAL0);
    endcase
    coin_sum = SUM_W'(time_cur) + coin_val;
    coin_sat = (coin_sum > SUM_W'(TIME_MAX)) ? TIME_W'(TIME_MAX) : coin_sum[TIME_W-1:0];
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      req_q       <= REQ_C0;
      time_load_q <= '0;
      load_en_q   <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      req_q       <= req_d;
      time_load_q <= time_load_d;
      load_en_q   <= load_en_d;
      busy_q      <= busy_d;
    end
  end

  // Outputs are computed for the state being entered, so they are valid in that state.
  always_comb begin
    state_d     = state_q;
    req_d       = req_q;
    time_load_d = time_load_q;
    load_en_d   = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (|btn_sync) begin
          req_d   = pick_req(btn_sync);
          state_d = ST_ADD;
        end
      end
      ST_ADD: begin
        case (req_q)
          REQ_PA:  time_load_d = TIME_W'(PRESET_A);
          REQ_PB:  time_load_d = TIME_W'(PRESET_B);
          default: time_load_d = coin_sat;
        endcase
        load_en_d = 1'b1;
        state_d   = ST_LOAD;
      end
      ST_LOAD: begin
        state_d = ST_RELEASE;
      end
      ST_RELEASE: begin
        if (!(|btn_sync)) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
    busy_d = (state_d != ST_IDLE);
  end

  assign time_load = time_load_q;
  assign load_en   = load_en_q;
  assign busy      = busy_q;

endmodule

// File: tb/tb_parking_coin_loader.sv
// Directed bench for parking_coin_loader: vector table of single presses plus
// hand-written reset and hold-through-reset sequences.
module tb_parking_coin_loader;

  logic        clk;
  logic        rst_n;
  logic [3:0]  coin;
  logic        preset_a;
  logic        preset_b;
  logic [13:0] time_cur;
  logic [13:0] time_load;
  logic        load_en;
  logic        busy;

  int checks;
  int errors;

  typedef struct {
    int         hold;
    logic [3:0] coin;
    logic       pa;
    logic       pb;
    int         tc;
    int         exp_tl;
  } vec_t;

  vec_t vecs [13];

  parking_coin_loader dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .coin      (coin),
    .preset_a  (preset_a),
    .preset_b  (preset_b),
    .time_cur  (time_cur),
    .time_load (time_load),
    .load_en   (load_en),
    .busy      (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Press at cycle 0 (just after an edge), hold v.hold cycles, observe hold+10 cycles.
  task automatic run_vec(input int idx, input vec_t v);
    int pulses;
    int first_k;
    int tl_at;
    int busy_ok;
    pulses  = 0;
    first_k = -1;
    tl_at   = -1;
    busy_ok = 1;
    @(posedge clk);
    #1;
    time_cur = 14'(v.tc);
    coin     = v.coin;
    preset_a = v.pa;
    preset_b = v.pb;
    for (int k = 1; k <= v.hold + 10; k++) begin
      @(posedge clk);
      #1;
      if (k == v.hold) begin
        coin     = 4'b0;
        preset_a = 1'b0;
        preset_b = 1'b0;
      end
      @(negedge clk);
      if (load_en) begin
        pulses++;
        if (first_k < 0) begin
          first_k = k;
          tl_at   = int'(time_load);
        end
      end
      if ((k >= 3 && k <= 5) && !busy) busy_ok = 0;
    end
    check($sformatf("vec%0d_pulses", idx), pulses, 1);
    check($sformatf("vec%0d_latency", idx), first_k, 4);
    check($sformatf("vec%0d_time_load", idx), tl_at, v.exp_tl);
    check($sformatf("vec%0d_busy_span", idx), busy_ok, 1);
    check($sformatf("vec%0d_idle_after", idx), int'(busy), 0);
    check($sformatf("vec%0d_tl_hold", idx), int'(time_load), v.exp_tl);
  endtask

  initial begin
    int pulses;
    int busy_cnt;
    int first_k;
    checks   = 0;
    errors   = 0;
    rst_n    = 1'b0;
    coin     = 4'b0;
    preset_a = 1'b0;
    preset_b = 1'b0;
    time_cur = 14'd0;

    vecs[0]  = '{10,  4'b1000, 1'b0, 1'b0, 500,   1000};
    vecs[1]  = '{2,   4'b0100, 1'b0, 1'b0, 9800,  9999};
    vecs[2]  = '{2,   4'b0001, 1'b0, 1'b0, 16383, 9999};
    vecs[3]  = '{2,   4'b0010, 1'b1, 1'b0, 40,    15};
    vecs[4]  = '{3,   4'b0000, 1'b0, 1'b1, 7000,  185};
    vecs[5]  = '{200, 4'b0001, 1'b0, 1'b0, 0,     50};
    vecs[6]  = '{3,   4'b0001, 1'b0, 1'b0, 50,    100};
    vecs[7]  = '{2,   4'b1001, 1'b0, 1'b0, 9499,  9999};
    vecs[8]  = '{2,   4'b0110, 1'b0, 1'b0, 10,    210};
    vecs[9]  = '{2,   4'b1111, 1'b1, 1'b1, 0,     185};
    vecs[10] = '{2,   4'b0001, 1'b0, 1'b0, 9950,  9999};
    vecs[11] = '{2,   4'b0001, 1'b0, 1'b0, 9948,  9998};
    vecs[12] = '{4,   4'b0000, 1'b1, 1'b0, 3000,  15};

    // Reset values
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_time_load", int'(time_load), 0);
    check("rst_load_en", int'(load_en), 0);
    check("rst_busy", int'(busy), 0);
    rst_n = 1'b1;
    repeat (2) @(posedge clk);

    for (int i = 0; i < 13; i++) run_vec(i, vecs[i]);

    // Reset while in ADD
    @(posedge clk);
    #1;
    time_cur = 14'd100;
    coin     = 4'b0100;
    for (int k = 1; k <= 3; k++) begin
      @(posedge clk);
      #1;
      if (k == 1) coin = 4'b0;
      @(negedge clk);
    end
    check("add_busy_before_rst", int'(busy), 1);
    rst_n = 1'b0;
    @(negedge clk);
    check("add_rst_load_en", int'(load_en), 0);
    check("add_rst_time_load", int'(time_load), 0);
    check("add_rst_busy", int'(busy), 0);
    rst_n = 1'b1;
    pulses   = 0;
    busy_cnt = 0;
    repeat (8) begin
      @(negedge clk);
      if (load_en) pulses++;
      if (busy) busy_cnt++;
    end
    check("add_rst_no_pulse", pulses, 0);
    check("add_rst_stays_idle", busy_cnt, 0);

    // Reset while in LOAD
    @(posedge clk);
    #1;
    time_cur = 14'd100;
    coin     = 4'b0100;
    for (int k = 1; k <= 4; k++) begin
      @(posedge clk);
      #1;
      if (k == 1) coin = 4'b0;
      @(negedge clk);
    end
    check("load_pulse_before_rst", int'(load_en), 1);
    check("load_tl_before_rst", int'(time_load), 300);
    rst_n = 1'b0;
    @(negedge clk);
    check("load_rst_load_en", int'(load_en), 0);
    check("load_rst_time_load", int'(time_load), 0);
    check("load_rst_busy", int'(busy), 0);
    rst_n = 1'b1;
    repeat (4) @(posedge clk);

    // Button held through reset is a fresh press afterwards
    @(posedge clk);
    #1;
    time_cur = 14'd1000;
    coin     = 4'b0010;
    repeat (8) @(posedge clk);
    @(negedge clk);
    check("held_first_tl", int'(time_load), 1150);
    rst_n = 1'b0;
    @(negedge clk);
    check("held_rst_tl", int'(time_load), 0);
    rst_n   = 1'b1;
    pulses  = 0;
    first_k = -1;
    for (int k = 1; k <= 10; k++) begin
      @(negedge clk);
      if (load_en) begin
        pulses++;
        if (first_k < 0) first_k = k;
      end
    end
    check("held_new_press_pulses", pulses, 1);
    check("held_new_press_latency", first_k, 4);
    check("held_new_press_tl", int'(time_load), 1150);
    check("held_busy_while_held", int'(busy), 1);
    @(posedge clk);
    #1;
    coin = 4'b0;
    repeat (6) @(posedge clk);
    @(negedge clk);
    check("held_idle_after_release", int'(busy), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
